panel_keyseq: RTL and testbench

PANEL_KEYSEQ -- requirements
Module: panel_keyseq

---
 rtl/panel_pkg.sv | 48 ++++
 rtl/panel_keycnt.sv | 35 +++
 rtl/panel_keyseq.sv | 204 ++++++++++++++++++++
 tb/tb_panel_keyseq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panel_pkg
//  Description : Shared key codes, response codes, FSM encoding and counter
//                sizing helper for the front-panel key sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package panel_pkg;

    localparam int unsigned c_NUM_KEYS = 12;

    localparam logic [3:0] c_KEY_START     = 4'd0;
    localparam logic [3:0] c_KEY_READ_IN   = 4'd1;
    localparam logic [3:0] c_KEY_MEM_CONT  = 4'd2;
    localparam logic [3:0] c_KEY_INST_CONT = 4'd3;
    localparam logic [3:0] c_KEY_MEM_STOP  = 4'd4;
    localparam logic [3:0] c_KEY_INST_STOP = 4'd5;
    localparam logic [3:0] c_KEY_EXEC      = 4'd6;
    localparam logic [3:0] c_KEY_IO_RESET  = 4'd7;
    localparam logic [3:0] c_KEY_DEP       = 4'd8;
    localparam logic [3:0] c_KEY_DEP_NXT   = 4'd9;
    localparam logic [3:0] c_KEY_EX        = 4'd10;
    localparam logic [3:0] c_KEY_EX_NXT    = 4'd11;

    localparam logic [1:0] c_ERR_OK      = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'd2;

    localparam int unsigned c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_SETUP = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_PRESS = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_WAIT  = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_RESP  = 3'd4;

    // The shared counter is loaded with (cycles - 1), so it must hold max-1.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/panel_keycnt.sv
`default_nettype none
// ============================================================================
//  Module      : panel_keycnt
//  Description : Loadable down-counter with zero flag; saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_keycnt
    import panel_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/panel_keyseq.sv
`default_nettype none
// ============================================================================
//  Module      : panel_keyseq
//  Description : Front-panel key sequencer: loads switches, presses one key
//                for a fixed time, waits for the processor ack, responds.
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_keyseq
    import panel_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 100,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [17:0] cmd_addr,
    input  logic [35:0] cmd_data,
    output logic        key_start,
    output logic        key_read_in,
    output logic        key_mem_cont,
    output logic        key_inst_cont,
    output logic        key_mem_stop,
    output logic        key_inst_stop,
    output logic        key_exec,
    output logic        key_io_reset,
    output logic        key_dep,
    output logic        key_dep_nxt,
    output logic        key_ex,
    output logic        key_ex_nxt,
    output logic [17:0] mas,
    output logic [35:0] datasw,
    input  logic        key_ack,
    input  logic [35:0] mi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [35:0] rsp_data,
    output logic [1:0]  rsp_err
);

    localparam int unsigned c_CW = cnt_width(HOLD_CYC, SETUP_CYC, TIMEOUT_CYC);
    localparam logic [c_CW-1:0] c_SETUP_LD = c_CW'(SETUP_CYC - 1);
    localparam logic [c_CW-1:0] c_HOLD_LD  = c_CW'(HOLD_CYC - 1);
    localparam logic [c_CW-1:0] c_TMO_LD   = c_CW'(TIMEOUT_CYC - 1);

    logic [c_ST_W-1:0]     r_state;
    logic [c_ST_W-1:0]     w_state_nxt;
    logic [3:0]            r_key;
    logic [17:0]           r_mas;
    logic [35:0]           r_datasw;
    logic                  r_ack_seen;
    logic [35:0]           r_rsp_data;
    logic [1:0]            r_rsp_err;
    logic                  w_legal;
    logic                  w_cnt_load;
    logic                  w_cnt_en;
    logic [c_CW-1:0]       w_cnt_val;
    logic                  w_cnt_zero;
    logic [c_NUM_KEYS-1:0] w_keys;

    assign w_legal = (cmd_key <= c_KEY_EX_NXT);

    // One counter times SETUP, PRESS and the ack timeout; in WAIT its
    // reload value minus the current count is the elapsed wait time.
    panel_keycnt #(
        .WIDTH (c_CW)
    ) u_keycnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_cnt_en    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_legal) begin
                        w_state_nxt = c_ST_SETUP;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = c_SETUP_LD;
                    end else begin
                        w_state_nxt = c_ST_RESP;
                    end
                end
            end
            c_ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_PRESS;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_HOLD_LD;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            c_ST_PRESS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_TMO_LD;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            c_ST_WAIT: begin
                if (r_ack_seen || w_cnt_zero) begin
                    w_state_nxt = c_ST_RESP;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == c_ST_IDLE);
        rsp_valid = (r_state == c_ST_RESP);
        w_keys    = '0;
        if (r_state == c_ST_PRESS) begin
            w_keys = {{(c_NUM_KEYS-1){1'b0}}, 1'b1} << r_key;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key      <= '0;
            r_mas      <= '0;
            r_datasw   <= '0;
            r_ack_seen <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= c_ERR_OK;
        end else begin
            if ((r_state == c_ST_IDLE) && cmd_valid) begin
                if (w_legal) begin
                    r_mas      <= cmd_addr;
                    r_datasw   <= cmd_data;
                    r_key      <= cmd_key;
                    r_ack_seen <= 1'b0;
                end else begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= c_ERR_ILLEGAL;
                end
            end
            if (((r_state == c_ST_PRESS) || (r_state == c_ST_WAIT)) && key_ack) begin
                r_ack_seen <= 1'b1;
            end
            // A recorded ack wins over a timeout expiring in the same cycle.
            if ((r_state == c_ST_WAIT) && (w_state_nxt == c_ST_RESP)) begin
                if (r_ack_seen) begin
                    r_rsp_data <= mi;
                    r_rsp_err  <= c_ERR_OK;
                end else begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= c_ERR_TIMEOUT;
                end
            end
        end
    end

    assign mas      = r_mas;
    assign datasw   = r_datasw;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

    assign key_start     = w_keys[c_KEY_START];
    assign key_read_in   = w_keys[c_KEY_READ_IN];
    assign key_mem_cont  = w_keys[c_KEY_MEM_CONT];
    assign key_inst_cont = w_keys[c_KEY_INST_CONT];
    assign key_mem_stop  = w_keys[c_KEY_MEM_STOP];
    assign key_inst_stop = w_keys[c_KEY_INST_STOP];
    assign key_exec      = w_keys[c_KEY_EXEC];
    assign key_io_reset  = w_keys[c_KEY_IO_RESET];
    assign key_dep       = w_keys[c_KEY_DEP];
    assign key_dep_nxt   = w_keys[c_KEY_DEP_NXT];
    assign key_ex        = w_keys[c_KEY_EX];
    assign key_ex_nxt    = w_keys[c_KEY_EX_NXT];

endmodule
`default_nettype wire

// File: tb/tb_panel_keyseq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_panel_keyseq
//  Description : Self-checking bench for panel_keyseq (vector table, random
//                commands against a rule-level model, reset corner case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_keyseq;

    localparam int HOLD  = 100;
    localparam int SETUP = 4;
    localparam int TMO   = 4096;
    localparam int C_REL = SETUP + HOLD + 1;   // first cycle (after accept) with keys released

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_key = '0;
    logic [17:0] cmd_addr = '0;
    logic [35:0] cmd_data = '0;
    logic        key_start, key_read_in, key_mem_cont, key_inst_cont;
    logic        key_mem_stop, key_inst_stop, key_exec, key_io_reset;
    logic        key_dep, key_dep_nxt, key_ex, key_ex_nxt;
    logic [17:0] mas;
    logic [35:0] datasw;
    logic        key_ack = 1'b0;
    logic [35:0] mi = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [35:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [11:0] keys;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] m_mas = '0;
    logic [35:0] m_dat = '0;

    always #5 clk = ~clk;

    assign keys = {key_ex_nxt, key_ex, key_dep_nxt, key_dep, key_io_reset, key_exec,
                   key_inst_stop, key_mem_stop, key_inst_cont, key_mem_cont,
                   key_read_in, key_start};

    panel_keyseq #(
        .HOLD_CYC    (HOLD),
        .SETUP_CYC   (SETUP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_key       (cmd_key),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .key_start     (key_start),
        .key_read_in   (key_read_in),
        .key_mem_cont  (key_mem_cont),
        .key_inst_cont (key_inst_cont),
        .key_mem_stop  (key_mem_stop),
        .key_inst_stop (key_inst_stop),
        .key_exec      (key_exec),
        .key_io_reset  (key_io_reset),
        .key_dep       (key_dep),
        .key_dep_nxt   (key_dep_nxt),
        .key_ex        (key_ex),
        .key_ex_nxt    (key_ex_nxt),
        .mas           (mas),
        .datasw        (datasw),
        .key_ack       (key_ack),
        .mi            (mi),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [3:0]  key;
        logic [17:0] addr;
        logic [35:0] data;
        logic [35:0] mi;
        int          ack_c;     // cycle after accept carrying key_ack, 0 = none
        int          rdly;      // cycles rsp_ready is held low
        logic [1:0]  exp_err;
        logic [35:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level outcome: ack only counts from PRESS onward, and must land
    // no later than the second-to-last timeout cycle to beat the timeout.
    function automatic void model(input logic [3:0] k, input int ack_c, input logic [35:0] m,
                                  output logic [1:0] err, output logic [35:0] dat);
        if (k > 4'd11) begin
            err = 2'd2; dat = '0;
        end else if (ack_c >= SETUP + 1 && ack_c <= C_REL + TMO - 2) begin
            err = 2'd0; dat = m;
        end else begin
            err = 2'd1; dat = '0;
        end
    endfunction

    task automatic run_cmd(input logic [3:0] k, input logic [17:0] a, input logic [35:0] d,
                           input logic [35:0] m, input int ack_c, input int rdly,
                           input logic [1:0] exp_err, input logic [35:0] exp_data);
        int c, rise, hi, rsp_c, exp_rsp_c;
        bit legal, other;
        logic [11:0] exp_key;
        legal = (k < 4'd12);
        c = 0;
        while (!cmd_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_key = k; cmd_addr = a; cmd_data = d; mi = m;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (legal) begin
            m_mas = a; m_dat = d;
        end
        if (!legal)
            exp_rsp_c = 1;
        else if (ack_c >= SETUP + 1 && ack_c <= C_REL + TMO - 2)
            exp_rsp_c = (((ack_c + 1) > C_REL) ? ack_c + 1 : C_REL) + 1;
        else
            exp_rsp_c = C_REL + TMO;
        exp_key = legal ? (12'd1 << k) : 12'd0;
        rise = 0; hi = 0; other = 0; rsp_c = 0;
        for (c = 1; c <= C_REL + TMO + 20 && rsp_c == 0; c++) begin
            if (keys != 12'd0) begin
                hi++;
                if (rise == 0) rise = c;
                if (keys != exp_key) other = 1;
            end
            if (c == 1 || c == SETUP) begin
                check("mas_setup", mas, m_mas);
                check("datasw_setup", datasw, m_dat);
            end
            if (rsp_valid) begin
                rsp_c = c;
            end else begin
                key_ack = (c == ack_c);
                @(negedge clk);
                key_ack = 1'b0;
            end
        end
        check("rsp_latency", rsp_c, exp_rsp_c);
        check("key_rise_cycle", rise, legal ? SETUP + 1 : 0);
        check("key_high_cycles", hi, legal ? HOLD : 0);
        check("wrong_key", other, 0);
        if (rsp_c == 0) return;
        check("rsp_err", rsp_err, exp_err);
        check("rsp_data", rsp_data, exp_data);
        check("mas_hold", mas, m_mas);
        check("datasw_hold", datasw, m_dat);
        cmd_valid = 1'b1; cmd_key = 4'd6;   // competing command must wait
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_data_hold", rsp_data, exp_data);
            check("rsp_err_hold", rsp_err, exp_err);
            check("cmd_ready_in_resp", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("mas_after", mas, m_mas);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  e_err;
        logic [35:0] e_dat;
        logic [3:0]  rk;
        int          rack, n_tmo;
        logic [35:0] rmi;

        vecs[0] = '{4'd10, 18'o1000, 36'o0,   36'o111777222666, C_REL + 20,      0,  2'd0, 36'o111777222666};
        vecs[1] = '{4'd8,  18'o2,    36'o123, 36'o5,            110,             2,  2'd0, 36'o5};
        vecs[2] = '{4'd0,  18'o7,    36'o0,   36'o777,          0,               1,  2'd1, 36'o0};
        vecs[3] = '{4'd14, 18'o3777, 36'o1,   36'o1,            0,               3,  2'd2, 36'o0};
        vecs[4] = '{4'd5,  18'o55,   36'o66,  36'h987654321,    50,              30, 2'd0, 36'h987654321};
        vecs[5] = '{4'd2,  18'o1,    36'o2,   36'h0ABCDEF01,    C_REL + TMO - 2, 0,  2'd0, 36'h0ABCDEF01};
        vecs[6] = '{4'd6,  18'o3,    36'o4,   36'h123,          C_REL + TMO - 1, 0,  2'd1, 36'o0};
        vecs[7] = '{4'd1,  18'o4,    36'o5,   36'h456,          3,               0,  2'd1, 36'o0};

        repeat (3) @(negedge clk);
        check("rst_keys", keys, 0);
        check("rst_mas", mas, 0);
        check("rst_datasw", datasw, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_cmd(vecs[i].key, vecs[i].addr, vecs[i].data, vecs[i].mi,
                    vecs[i].ack_c, vecs[i].rdly, vecs[i].exp_err, vecs[i].exp_data);

        // Reset at PRESS clock 50 discards the command silently.
        cmd_valid = 1'b1; cmd_key = 4'd0; cmd_addr = 18'o17; cmd_data = 36'o17;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c < SETUP + 50; c++) @(negedge clk);
        check("press50_key_high", key_start, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstpress_keys", keys, 0);
        check("rstpress_rsp_valid", rsp_valid, 0);
        check("rstpress_cmd_ready", cmd_ready, 1);
        check("rstpress_mas", mas, 0);
        reset = 1'b0;
        m_mas = '0; m_dat = '0;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                if (rsp_valid || keys != 0) seen = 1;
            end
            check("rstpress_no_activity", seen, 0);
        end

        n_tmo = 0;
        for (int i = 0; i < 25; i++) begin
            rk  = 4'($urandom_range(0, 15));
            rmi = 36'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0 && n_tmo < 1) begin
                rack = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, SETUP);
                if (rk < 4'd12) n_tmo++;
            end else begin
                rack = $urandom_range(SETUP + 1, C_REL + 60);
            end
            model(rk, rack, rmi, e_err, e_dat);
            run_cmd(rk, 18'($urandom()), 36'({$urandom(), $urandom()}), rmi,
                    rack, $urandom_range(0, 4), e_err, e_dat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
